// File: rtl/wavetable_pkg.sv
// Shared types and sizing for the wavetable voice scheduler.
// Optional build macro: WVS_SATURATE_EN (clamp frame mix to DATA_W range).
package wavetable_pkg;

  localparam int NUM_VOICES = 8;
  localparam int PHASE_W    = 32;
  localparam int LUT_BITS   = 10;
  localparam int DATA_W     = 24;
  localparam int NUM_WAVES  = 4;
  localparam int NUM_BANDS  = 22;

  localparam int VOICE_W = $clog2(NUM_VOICES);
  localparam int WAVE_W  = $clog2(NUM_WAVES);
  localparam int BAND_W  = $clog2(NUM_BANDS);
  localparam int MIX_W   = DATA_W + VOICE_W;

  typedef enum logic [WAVE_W-1:0] {
    SQUARE   = 2'd0,
    SAW      = 2'd1,
    TRIANGLE = 2'd2,
    SINE     = 2'd3
  } wave_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } sched_state_e;

  typedef struct packed {
    logic [PHASE_W-1:0] inc;
    logic [WAVE_W-1:0]  wave;
    logic [BAND_W-1:0]  band;
    logic               gate;
  } voice_cfg_t;

  function automatic logic [BAND_W-1:0] clamp_band(
    input logic [BAND_W-1:0] b
  );
    if (b > BAND_W'(NUM_BANDS - 1))
      return BAND_W'(NUM_BANDS - 1);
    return b;
  endfunction

endpackage

// File: rtl/wavetable_voice_scheduler_bank.sv
// Per-voice configuration registers and phase accumulators.
// Write port handles gate edges and band clamping; read port advances voice k.
module wavetable_voice_bank
  import wavetable_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               we_i,
  input  logic [VOICE_W-1:0] wr_voice_i,
  input  logic [PHASE_W-1:0] wr_inc_i,
  input  logic [WAVE_W-1:0]  wr_wave_i,
  input  logic [BAND_W-1:0]  wr_band_i,
  input  logic               wr_gate_i,
  input  logic [VOICE_W-1:0] rd_voice_i,
  input  logic               adv_i,
  output logic [WAVE_W-1:0]  rd_wave_o,
  output logic [BAND_W-1:0]  rd_band_o,
  output logic               rd_gate_o,
  output logic [PHASE_W-1:0] rd_acc_o
);

  voice_cfg_t         cfg_q [NUM_VOICES];
  logic [PHASE_W-1:0] acc_q [NUM_VOICES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        cfg_q[v] <= '0;
        acc_q[v] <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (we_i && wr_voice_i == VOICE_W'(v)) begin
          cfg_q[v].inc  <= wr_inc_i;
          cfg_q[v].wave <= wr_wave_i;
          cfg_q[v].band <= clamp_band(wr_band_i);
          cfg_q[v].gate <= wr_gate_i;
        end
        // advance uses the stored (old) cfg; a gate rise restarts the phase
        if (we_i && wr_voice_i == VOICE_W'(v)
            && wr_gate_i && !cfg_q[v].gate)
          acc_q[v] <= '0;
        else if (adv_i && rd_voice_i == VOICE_W'(v)
                 && cfg_q[v].gate)
          acc_q[v] <= acc_q[v] + cfg_q[v].inc;
      end
    end
  end

  assign rd_wave_o = cfg_q[rd_voice_i].wave;
  assign rd_band_o = cfg_q[rd_voice_i].band;
  assign rd_gate_o = cfg_q[rd_voice_i].gate;
  assign rd_acc_o  = acc_q[rd_voice_i];

endmodule

// File: rtl/wavetable_voice_scheduler.sv
// Frame scheduler: one ROM lookup per voice per tick, summed into one mix.
// Optional build macro: WVS_SATURATE_EN (clamp mix to DATA_W range).
module wavetable_voice_scheduler
  import wavetable_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    sample_tick_i,
  input  logic                    cfg_we_i,
  input  logic [VOICE_W-1:0]      cfg_voice_i,
  input  logic [PHASE_W-1:0]      cfg_inc_i,
  input  logic [WAVE_W-1:0]       cfg_wave_i,
  input  logic [BAND_W-1:0]       cfg_band_i,
  input  logic                    cfg_gate_i,
  output logic [WAVE_W-1:0]       rom_wave_o,
  output logic [BAND_W-1:0]       rom_band_o,
  output logic [LUT_BITS-1:0]     rom_phase_o,
  input  logic [DATA_W-1:0]       rom_data_i,
  output logic signed [MIX_W-1:0] mix_o,
  output logic                    mix_valid_o,
  output logic                    busy_o,
  output logic                    overrun_o
);

  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  sched_state_e       state_q, state_d;
  logic [VOICE_W-1:0] k_q;
  logic               start, issue;

  logic [WAVE_W-1:0]  rd_wave;
  logic [BAND_W-1:0]  rd_band;
  logic               rd_gate;
  logic [PHASE_W-1:0] rd_acc;

  wavetable_voice_bank u_bank (
    .clk_i      (clk_i),
    .rst_ni     (rst_n),
    .we_i       (cfg_we_i),
    .wr_voice_i (cfg_voice_i),
    .wr_inc_i   (cfg_inc_i),
    .wr_wave_i  (cfg_wave_i),
    .wr_band_i  (cfg_band_i),
    .wr_gate_i  (cfg_gate_i),
    .rd_voice_i (k_q),
    .adv_i      (issue),
    .rd_wave_o  (rd_wave),
    .rd_band_o  (rd_band),
    .rd_gate_o  (rd_gate),
    .rd_acc_o   (rd_acc)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (sample_tick_i) state_d = ISSUE;
      ISSUE: if (k_q == VOICE_W'(NUM_VOICES - 1))
               state_d = DRAIN;
      DRAIN: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != IDLE);
    issue       = (state_q == ISSUE);
    mix_valid_o = (state_q == DONE);
    start       = (state_q == IDLE) && sample_tick_i;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)     k_q <= '0;
    else if (start) k_q <= '0;
    else if (issue) k_q <= k_q + 1'b1;
  end

  logic [WAVE_W-1:0]   live_wave, wave_q;
  logic [BAND_W-1:0]   live_band, band_q;
  logic [LUT_BITS-1:0] live_phase, phase_q;

  assign live_wave  = rd_wave;
  assign live_band  = (rd_wave == SINE) ? '0 : rd_band;
  assign live_phase = rd_acc[PHASE_W-1 -: LUT_BITS];

  // ROM address is live during ISSUE and holds the last issue otherwise
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wave_q  <= '0;
      band_q  <= '0;
      phase_q <= '0;
    end else if (issue) begin
      wave_q  <= live_wave;
      band_q  <= live_band;
      phase_q <= live_phase;
    end
  end

  assign rom_wave_o  = issue ? live_wave  : wave_q;
  assign rom_band_o  = issue ? live_band  : band_q;
  assign rom_phase_o = issue ? live_phase : phase_q;

  logic                    tag_valid, tag_gate;
  logic signed [MIX_W-1:0] acc_mix, data_ext, add_val, sum_next;
  logic signed [MIX_W-1:0] mix_fin;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= 1'b0;
      tag_gate  <= 1'b0;
    end else begin
      tag_valid <= issue;
      tag_gate  <= rd_gate;
    end
  end

  assign data_ext = {{VOICE_W{rom_data_i[DATA_W-1]}}, rom_data_i};
  assign add_val  = (tag_valid && tag_gate) ? data_ext : '0;
  assign sum_next = acc_mix + add_val;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)         acc_mix <= '0;
    else if (start)     acc_mix <= '0;
    else if (tag_valid) acc_mix <= sum_next;
  end

`ifdef WVS_SATURATE_EN
  localparam logic signed [MIX_W-1:0] SAT_HI =
    {{(VOICE_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [MIX_W-1:0] SAT_LO =
    {{(VOICE_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  always_comb begin
    mix_fin = sum_next;
    if (sum_next > SAT_HI)      mix_fin = SAT_HI;
    else if (sum_next < SAT_LO) mix_fin = SAT_LO;
  end
`else
  assign mix_fin = sum_next;
`endif

  // last voice lands during DRAIN, so the frame result is ready entering DONE
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)                mix_o <= '0;
    else if (state_q == DRAIN) mix_o <= mix_fin;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)                        overrun_o <= 1'b0;
    else if (sample_tick_i && busy_o)  overrun_o <= 1'b1;
  end

endmodule

// File: tb/tb_wavetable_voice_scheduler.sv
// Directed self-checking bench for wavetable_voice_scheduler.
// Expected mix values follow WVS_SATURATE_EN when it is defined.
module tb_wavetable_voice_scheduler;
  import wavetable_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic        we;
  logic [2:0]  cv;
  logic [31:0] ci;
  logic [1:0]  cwv;
  logic [4:0]  cb;
  logic        cg;
  logic [1:0]  rw;
  logic [4:0]  rb;
  logic [9:0]  rp;
  logic [23:0] rom_data;
  logic [23:0] rom_val;
  logic signed [26:0] mix;
  logic        mv;
  logic        busy;
  logic        ovr;

  wavetable_voice_scheduler dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .sample_tick_i (tick),
    .cfg_we_i      (we),
    .cfg_voice_i   (cv),
    .cfg_inc_i     (ci),
    .cfg_wave_i    (cwv),
    .cfg_band_i    (cb),
    .cfg_gate_i    (cg),
    .rom_wave_o    (rw),
    .rom_band_o    (rb),
    .rom_phase_o   (rp),
    .rom_data_i    (rom_data),
    .mix_o         (mix),
    .mix_valid_o   (mv),
    .busy_o        (busy),
    .overrun_o     (ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_val;

  int passed = 0;
  int total  = 0;

  logic [9:0] ph [1:19];
  logic [4:0] bd [1:19];
  logic [1:0] wv [1:19];
  int         vcyc;
  int         vcnt;
  logic signed [26:0] mixv;

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cfg(input logic [2:0] v, input logic [31:0] inc,
                     input logic [1:0] w, input logic [4:0] b,
                     input logic g);
    @(negedge clk);
    we = 1'b1; cv = v; ci = inc; cwv = w; cb = b; cg = g;
    @(negedge clk);
    we = 1'b0;
  endtask

  // tick at cycle 0, observe cycles 1..19; optional extra tick and
  // a voice-2 write at chosen cycles
  task automatic frame(input int tick2_c, input int wr_c,
                       input logic [31:0] wr_inc);
    @(negedge clk);
    tick = 1'b1;
    vcyc = 0;
    vcnt = 0;
    mixv = '0;
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      tick = (c == tick2_c);
      we   = (c == wr_c);
      if (c == wr_c) begin
        cv = 3'd2; ci = wr_inc; cwv = 2'd1; cb = 5'd0; cg = 1'b1;
      end
      ph[c] = rp;
      bd[c] = rb;
      wv[c] = rw;
      if (mv) begin
        if (vcnt == 0) begin
          vcyc = c;
          mixv = mix;
        end
        vcnt++;
      end
    end
    tick = 1'b0;
    we   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; we = 1'b0;
    cv = '0; ci = '0; cwv = '0; cb = '0; cg = 1'b0;
    rom_val = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mix", mix, 0);
    chk("rst_valid", mv, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_phase", rp, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // voice 0 saw, band 3, phase steps by one LUT entry per frame
    cfg(3'd0, 32'h0040_0000, 2'd1, 5'd3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      frame(0, 0, '0);
      chk($sformatf("v0_phase_%0d", i), ph[1], i);
      chk($sformatf("v0_band_%0d", i), bd[1], 3);
      chk($sformatf("valid_cyc_%0d", i), vcyc, 10);
      chk($sformatf("valid_cnt_%0d", i), vcnt, 1);
    end

    // voices 0 and 5 at positive full scale
    cfg(3'd5, 32'h0040_0000, 2'd0, 5'd0, 1'b1);
    rom_val = 24'h7F_FFFF;
    frame(0, 0, '0);
`ifdef WVS_SATURATE_EN
    chk("mix_pos2", mixv, 8388607);
`else
    chk("mix_pos2", mixv, 16777214);
`endif

    // all voices at negative full scale
    for (int v = 1; v < 8; v++)
      cfg(3'(v), 32'h0, 2'd0, 5'd0, 1'b1);
    rom_val = 24'h80_0000;
    frame(0, 0, '0);
`ifdef WVS_SATURATE_EN
    chk("mix_neg8", mixv, -8388608);
`else
    chk("mix_neg8", mixv, -67108864);
`endif

    // tick while busy
    chk("ovr_before", ovr, 0);
    frame(4, 0, '0);
    chk("ovr_pulses", vcnt, 1);
    chk("ovr_set", ovr, 1);
    repeat (30) @(negedge clk);
    chk("ovr_sticky", ovr, 1);

    // reset in the middle of ISSUE
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ovr", ovr, 0);
    chk("arst_mix", mix, 0);
    chk("arst_valid", mv, 0);
    chk("arst_phase", rp, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // cfg write on voice 2's own issue cycle
    cfg(3'd2, 32'h0040_0000, 2'd1, 5'd0, 1'b1);
    frame(0, 0, '0);
    chk("v2_f0", ph[3], 0);
    frame(0, 3, 32'h0080_0000);
    chk("v2_f1", ph[3], 1);
    frame(0, 0, '0);
    chk("v2_f2_old_step", ph[3], 2);
    frame(0, 0, '0);
    chk("v2_f3_new_step", ph[3], 4);
    cfg(3'd2, 32'h0080_0000, 2'd1, 5'd0, 1'b0);
    frame(0, 0, '0);
    chk("v2_gate_off", ph[3], 6);
    frame(0, 0, '0);
    chk("v2_hold", ph[3], 6);
    cfg(3'd2, 32'h0080_0000, 2'd1, 5'd0, 1'b1);
    frame(0, 0, '0);
    chk("v2_regate", ph[3], 0);
    frame(0, 0, '0);
    chk("v2_after_regate", ph[3], 2);

    // band clamp and sine band override
    cfg(3'd3, 32'h0, 2'd1, 5'd31, 1'b1);
    cfg(3'd4, 32'h0, 2'd3, 5'd7, 1'b1);
    frame(0, 0, '0);
    chk("band_clamp", bd[4], 21);
    chk("v3_wave", wv[4], 1);
    chk("sine_band", bd[5], 0);
    chk("sine_wave", wv[5], 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wavetable_voice_scheduler.md
Name: wavetable_voice_scheduler

Overview:
Time-multiplexes the single-port wavetable ROM lookup among NUM_VOICES polyphonic voices.
- Holds per-voice phase accumulators and configuration.
- On each audio-frame tick, issues one ROM lookup per voice on consecutive cycles and sums the returned samples.
- Presents one mixed sample per frame to the output stage.
- Sits between the control-register/MIDI front end and the wavetable ROM plus DAC path.

Parameters:
- NUM_VOICES, 8, voices served per frame (power of two, ≥2).
- PHASE_W, 32, phase accumulator and increment width.
- LUT_BITS, 10, ROM phase index width; index = top LUT_BITS of the accumulator.
- DATA_W, 24, signed ROM sample width.
- NUM_WAVES, 4, waveform types.
- NUM_BANDS, 22, band-limited tables per band-limited waveform.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- sample_tick_i  in  1  one-cycle frame-start strobe.
- cfg_we_i  in  1  voice configuration write strobe.
- cfg_voice_i  in  $clog2(NUM_VOICES)  target voice.
- cfg_inc_i  in  PHASE_W  phase increment per frame.
- cfg_wave_i  in  $clog2(NUM_WAVES)  waveform select.
- cfg_band_i  in  $clog2(NUM_BANDS)  band index.
- cfg_gate_i  in  1  voice on/off.
- rom_wave_o  out  $clog2(NUM_WAVES)  to ROM waveform select.
- rom_band_o  out  $clog2(NUM_BANDS)  to ROM band select.
- rom_phase_o  out  LUT_BITS  to ROM phase index.
- rom_data_i  in  DATA_W  signed ROM data; registered, 1-cycle latency.
- mix_o  out  DATA_W+$clog2(NUM_VOICES)  signed frame mix.
- mix_valid_o  out  1  one-cycle pulse, mix_o updated.
- busy_o  out  1  high while a frame is in progress.
- overrun_o  out  1  sticky: tick arrived while busy.

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - All voice registers, accumulators and outputs go to 0.
  - FSM goes to IDLE.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: sample_tick_i → ISSUE with voice counter k=0.
  - ISSUE: each cycle drives rom_* for voice k.
    - rom_phase_o = acc[k][PHASE_W-1 -: LUT_BITS].
    - If gate[k]: acc[k] += inc[k], wrapping modulo 2^PHASE_W.
    - k increments; after k=NUM_VOICES-1 go to DRAIN.
  - DRAIN: one cycle to capture the last voice's data.
  - DONE: mix_o ← accumulator, mix_valid_o=1 for this cycle only, then go to IDLE.
- Timing: tick sampled at cycle 0; voice k issued at cycle k+1; its data is captured at cycle k+2. mix_valid_o is high at cycle NUM_VOICES+2, i.e. 10 cycles with defaults.
- Accumulation:
  - A 1-deep pipeline tag {valid, gate} follows each issue.
  - Captured data is sign-extended to the mix width and added only when the tag's gate=1; gated-off voices contribute 0.
  - The mix accumulator clears on the ISSUE entry cycle.
- rom_* outputs hold their last value outside ISSUE.
- busy_o = (state != IDLE).
- sample_tick_i while busy: ignored, overrun_o set; it is cleared only by reset.
- cfg writes are accepted in any state, one voice per cycle.
  - A write to the voice being issued in the same cycle: the issue uses the old values; the new values apply from the next frame.
  - Gate rising (stored gate 0, written 1) resets acc to 0.
  - Gate falling holds acc.
  - cfg_band_i > NUM_BANDS-1 is stored clamped to NUM_BANDS-1.
- For wave = sine (value NUM_WAVES-1), rom_band_o is driven 0.

Optional Feature:
- Macro WVS_SATURATE_EN.
- Defined: the DONE-stage mix is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1] before sign-extending onto mix_o.
- Undefined: mix_o carries the full-width sum, with no clamping.
- Port widths are identical in both builds.

Decomposition:
- Package wavetable_pkg:
  - wave_e enum: SQUARE=0, SAW=1, TRIANGLE=2, SINE=3.
  - Constants: LUT_BITS, DATA_W, NUM_WAVES, NUM_BANDS.
  - voice_cfg_t struct: inc, wave, band, gate.
  - Scheduler state enum.
- Sub-module wavetable_voice_bank:
  - Register file of voice_cfg_t plus accumulators.
  - Write port with gate-edge logic and band clamp.
  - Read/advance port indexed by k.

Test Plan:
- Voice 0: gate=1, inc=2^22, wave=SAW, band=3; 4 ticks spaced 20 cycles → rom_phase_o 0,1,2,3 on voice-0 issue cycles; rom_band_o=3; mix_valid_o exactly 10 cycles after each tick.
- Voices 0 and 5 gated, stub ROM returns 24'h7FFFFF for both → mix_o = 2×(2^23-1) = 16777214; with WVS_SATURATE_EN → 8388607.
- All 8 voices gated, ROM returns 24'h800000 → mix_o = -8×2^23 = -67108864; with WVS_SATURATE_EN → -8388608.
- Tick at cycle 4 of a frame → ignored, overrun_o=1 and stays 1, only one mix_valid_o pulse; rst_ni low mid-ISSUE → all outputs 0 immediately, busy_o=0.
- cfg write to voice 2 on voice 2's issue cycle, inc 2^22→2^23 → that frame uses the old phase step; the next frame steps by 2; re-gate 0→1 → phase index restarts at 0.
- cfg_band_i=31 → stored 21; wave=SINE → rom_band_o=0.
